// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and execute-stage data access.
// Define ARB_TIMEOUT_EN to add a busy timeout that force-completes an access with bus_err.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_ren,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        flush,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_en,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy,
  output logic        pipe_stall,
  output logic        bus_err
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 1) begin : gen_param_check
    $error("mem_port_arbiter: STARVE_LIMIT must be 1..15 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [1:0] {StIdle, StIfetch, StDaccess} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [3:0]  starve_q;
  logic        wen_q;
  logic        discard_q;

  logic data_req, starved, grant_fetch, grant_data;
  logic active, done, timeout_hit, discard_now;

  always_comb begin
    data_req    = d_ren | d_wen;
    starved     = if_ren && (starve_q == 4'(STARVE_LIMIT));
    grant_fetch = if_ren && (!data_req || starved);
    grant_data  = data_req && !grant_fetch;
    active      = (state_q != StIdle);
    done        = active && (!mem_busy || timeout_hit);
    // A flush in the completion cycle itself must already suppress if_ready.
    discard_now = discard_q | flush;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      starve_q  <= '0;
      wen_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_fetch) begin
            state_q   <= StIfetch;
            addr_q    <= if_addr;
            wdata_q   <= '0;
            be_q      <= 4'hf;
            wen_q     <= 1'b0;
            starve_q  <= '0;
            discard_q <= flush;
          end else if (grant_data) begin
            // Simultaneous read and write requests are treated as a write.
            state_q <= StDaccess;
            addr_q  <= d_addr;
            wdata_q <= d_wen ? d_wdata : '0;
            be_q    <= d_wen ? d_byte_en : 4'hf;
            wen_q   <= d_wen;
            if (if_ren) starve_q <= starve_q + 4'd1;
          end
        end
        StIfetch: begin
          if (done) begin
            state_q   <= StIdle;
            discard_q <= 1'b0;
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        StDaccess: begin
          if (done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TimerW-1:0] timer_q;

  // Counts busy strobe cycles of the current access; idle cycles always precede a grant.
  always_ff @(posedge CLK) begin
    if (RST || state_q == StIdle) begin
      timer_q <= '0;
    end else if (mem_busy && !timeout_hit) begin
      timer_q <= timer_q + TimerW'(1);
    end
  end

  assign timeout_hit = active && (timer_q == TimerW'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    if_ready    = !RST && (state_q == StIfetch) && done && !discard_now;
    d_ready     = !RST && (state_q == StDaccess) && done;
    if_rdata    = (if_ready && !timeout_hit) ? mem_rdata : '0;
    d_rdata     = (d_ready && !wen_q && !timeout_hit) ? mem_rdata : '0;
    mem_ren     = !timeout_hit && ((state_q == StIfetch) || (state_q == StDaccess && !wen_q));
    mem_wen     = !timeout_hit && (state_q == StDaccess) && wen_q;
    mem_addr    = active ? addr_q : '0;
    mem_wdata   = active ? wdata_q : '0;
    mem_byte_en = active ? be_q : '0;
    pipe_stall  = (if_ren & ~if_ready) | ((d_ren | d_wen) & ~d_ready);
    bus_err     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    bus_err     = (if_ready | d_ready) & timeout_hit;
`endif
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cycle vectors, corner sequences and a
// randomized run against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int unsigned StarveLimit   = 4;
  localparam int unsigned TimeoutCycles = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_ren, flush, d_ren, d_wen, mem_busy;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_byte_en;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_ren, mem_wen, pipe_stall, bus_err;
  logic [3:0]  mem_byte_en;

  mem_port_arbiter #(
    .STARVE_LIMIT  (StarveLimit),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .if_ren     (if_ren),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ready   (if_ready),
    .flush      (flush),
    .d_ren      (d_ren),
    .d_wen      (d_wen),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_byte_en  (d_byte_en),
    .d_rdata    (d_rdata),
    .d_ready    (d_ready),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byte_en(mem_byte_en),
    .mem_rdata  (mem_rdata),
    .mem_busy   (mem_busy),
    .pipe_stall (pipe_stall),
    .bus_err    (bus_err)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic rst, ifr; logic [31:0] ia; logic fl, dr, dw; logic [31:0] da, dwd; logic [3:0] dbe;
    logic busy; logic [31:0] rd;
    logic mren, mwen; logic [31:0] maddr; logic [3:0] mbe; logic [31:0] mwd;
    logic ifrdy, drdy, stall; logic [31:0] rdx;
  } vec_t;

  typedef logic [31:0] row_t [20];

  function automatic vec_t mk(input row_t f);
    vec_t v;
    v.rst = f[0][0];   v.ifr = f[1][0];   v.ia = f[2];       v.fl = f[3][0];
    v.dr = f[4][0];    v.dw = f[5][0];    v.da = f[6];       v.dwd = f[7];
    v.dbe = f[8][3:0]; v.busy = f[9][0];  v.rd = f[10];      v.mren = f[11][0];
    v.mwen = f[12][0]; v.maddr = f[13];   v.mbe = f[14][3:0]; v.mwd = f[15];
    v.ifrdy = f[16][0]; v.drdy = f[17][0]; v.stall = f[18][0]; v.rdx = f[19];
    return v;
  endfunction

  vec_t vecs[$];

  task automatic do_reset();
    RST = 1'b1; if_ren = 0; if_addr = 0; flush = 0; d_ren = 0; d_wen = 0; d_addr = 0;
    d_wdata = 0; d_byte_en = 0; mem_busy = 0; mem_rdata = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic run_vectors();
    vec_t  v;
    string p;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge CLK); #1;
      RST = v.rst; if_ren = v.ifr; if_addr = v.ia; flush = v.fl; d_ren = v.dr; d_wen = v.dw;
      d_addr = v.da; d_wdata = v.dwd; d_byte_en = v.dbe; mem_busy = v.busy; mem_rdata = v.rd;
      @(negedge CLK);
      p = $sformatf("vec%0d", i);
      chk({p, " mem_ren"}, mem_ren, v.mren);
      chk({p, " mem_wen"}, mem_wen, v.mwen);
      chk({p, " if_ready"}, if_ready, v.ifrdy);
      chk({p, " d_ready"}, d_ready, v.drdy);
      chk({p, " pipe_stall"}, pipe_stall, v.stall);
      if (v.mren || v.mwen) begin
        chk({p, " mem_addr"}, mem_addr, v.maddr);
        chk({p, " mem_byte_en"}, mem_byte_en, v.mbe);
      end
      if (v.mwen) chk({p, " mem_wdata"}, mem_wdata, v.mwd);
      if (v.ifrdy) chk({p, " if_rdata"}, if_rdata, v.rdx);
      if (v.drdy && !v.mwen) chk({p, " d_rdata"}, d_rdata, v.rdx);
    end
  endtask

  // Model: one access at a time, chosen in an idle cycle from the pending requests.
  task automatic run_random(input int cycles);
    bit f_pend = 0, dp = 0, rd_k = 0, wr_k = 0, disc_q = 0, c_wr = 0;
    logic [31:0] fa = 0, da_k = 0, dwd_k = 0, c_addr = 0, c_wd = 0;
    logic [3:0] dbe_k = 0, c_be = 0;
    int cur = 0, starve = 0, busy_cnt = 0, k;
    bit e_if, e_d, e_err, e_r, e_w, timed, done, disc, gf, e_stall;
    for (int n = 0; n < cycles; n++) begin
      @(posedge CLK); #1;
      if (!f_pend && $urandom_range(0, 2) == 0) begin
        f_pend = 1; fa = $urandom & 32'h0000_fffc;
      end
      if (!dp && $urandom_range(0, 3) == 0) begin
        dp = 1; k = $urandom_range(0, 4);
        rd_k = (k < 2) || (k == 4); wr_k = (k >= 2);
        da_k = $urandom; dwd_k = $urandom; dbe_k = 4'($urandom_range(1, 15));
      end
      if_ren = f_pend; if_addr = fa; d_ren = dp & rd_k; d_wen = dp & wr_k;
      d_addr = da_k; d_wdata = dwd_k; d_byte_en = dbe_k;
      flush = ($urandom_range(0, 7) == 0);
      mem_busy = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      @(negedge CLK);
      timed   = TimeoutEn && cur != 0 && busy_cnt == int'(TimeoutCycles);
      done    = cur != 0 && (!mem_busy || timed);
      disc    = disc_q || flush;
      e_r     = !timed && (cur == 1 || (cur == 2 && !c_wr));
      e_w     = !timed && cur == 2 && c_wr;
      e_if    = cur == 1 && done && !disc;
      e_d     = cur == 2 && done;
      e_err   = timed && (e_if || e_d);
      e_stall = (if_ren && !e_if) || ((d_ren || d_wen) && !e_d);
      chk("rnd mem_ren", mem_ren, e_r);
      chk("rnd mem_wen", mem_wen, e_w);
      chk("rnd if_ready", if_ready, e_if);
      chk("rnd d_ready", d_ready, e_d);
      chk("rnd bus_err", bus_err, e_err);
      chk("rnd pipe_stall", pipe_stall, e_stall);
      if (e_r || e_w) begin
        chk("rnd mem_addr", mem_addr, c_addr);
        chk("rnd mem_byte_en", mem_byte_en, c_be);
      end
      if (e_w) chk("rnd mem_wdata", mem_wdata, c_wd);
      if (e_if) chk("rnd if_rdata", if_rdata, timed ? 32'h0 : mem_rdata);
      if (e_d && !c_wr) chk("rnd d_rdata", d_rdata, timed ? 32'h0 : mem_rdata);
      if (cur == 0) begin
        if (f_pend || dp) begin
          gf = f_pend && (!dp || starve == int'(StarveLimit));
          busy_cnt = 0;
          if (gf) begin
            cur = 1; c_addr = fa; c_be = 4'hf; c_wr = 0; c_wd = 0; starve = 0; disc_q = flush;
          end else begin
            cur = 2; c_addr = da_k; c_wr = wr_k; c_be = wr_k ? dbe_k : 4'hf; c_wd = dwd_k;
            if (f_pend) starve++;
          end
        end
      end else if (done) begin
        cur = 0; disc_q = 0;
      end else begin
        if (cur == 1 && flush) disc_q = 1;
        if (mem_busy) busy_cnt++;
      end
      if (if_ready) f_pend = 0;
      else if (flush && f_pend) fa = $urandom & 32'h0000_fffc;
      if (d_ready) dp = 0;
    end
  endtask

  task automatic run_starve();
    int grants;
    bit fetched;
    do_reset();
    for (int round = 0; round < 2; round++) begin
      grants = 0; fetched = 0;
      for (int c = 0; c < 40 && !fetched; c++) begin
        @(posedge CLK); #1;
        if_ren = 1; if_addr = 32'h700; d_ren = 1; d_addr = 32'h800; mem_busy = 0;
        @(negedge CLK);
        if (mem_ren && mem_addr == 32'h800) grants++;
        if (mem_ren && mem_addr == 32'h700) fetched = 1;
      end
      chk($sformatf("starve round%0d fetch granted", round), 32'(fetched), 32'h1);
      chk($sformatf("starve round%0d data grants", round), 32'(grants), StarveLimit);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic run_timeout();
    int strobe_at = -1;
    bit got = 0;
    do_reset();
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge CLK); #1;
      d_ren = 1; d_addr = 32'h900; mem_busy = 1; mem_rdata = 32'hffff_ffff;
      @(negedge CLK);
      if (strobe_at < 0 && mem_ren) strobe_at = c;
      if (d_ready) begin
        got = 1;
        chk("timeout bus_err", bus_err, 1);
        chk("timeout d_rdata", d_rdata, 0);
        chk("timeout strobe dropped", mem_ren, 0);
        chk("timeout distance", 32'(c - strobe_at), TimeoutCycles);
      end
    end
    chk("timeout ready seen", 32'(got), 32'h1);
    do_reset();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge CLK);
    chk("reset mem_ren", mem_ren, 0);
    chk("reset mem_wen", mem_wen, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset mem_byte_en", mem_byte_en, 0);
    chk("reset if_ready", if_ready, 0);
    chk("reset d_ready", d_ready, 0);
    chk("reset if_rdata", if_rdata, 0);
    chk("reset d_rdata", d_rdata, 0);
    chk("reset bus_err", bus_err, 0);
    chk("reset pipe_stall", pipe_stall, 0);

    //              rst ifr ia fl dr dw da dwd dbe busy rd | mren mwen maddr mbe mwd ifrdy drdy stall rdx
    vecs.push_back(mk('{1, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 'hdeadbeef,
                        1, 0, 'h100, 'hf, 0, 1, 0, 0, 'hdeadbeef}));
    vecs.push_back(mk('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}));
    vecs.push_back(mk('{0, 1, 'h300, 0, 0, 1, 'h200, 'h12345678, 'h3, 1, 0,
                        0, 0, 0, 0, 0, 0, 0, 1, 0}));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk('{0, 1, 'h300, 0, 0, 1, 'h200, 'h12345678, 'h3, 1, 0,
                          0, 1, 'h200, 'h3, 'h12345678, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h300, 0, 0, 1, 'h200, 'h12345678, 'h3, 0, 0,
                        0, 1, 'h200, 'h3, 'h12345678, 0, 1, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h300, 0, 0, 0, 0, 0, 0, 0, 'hcafef00d,
                        1, 0, 'h300, 'hf, 0, 1, 0, 0, 'hcafef00d}));
    vecs.push_back(mk('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}));
    vecs.push_back(mk('{0, 1, 'h400, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h400, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 'h400, 'hf, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h400, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 'h400, 'hf, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h400, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 'h400, 'hf, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h400, 0, 0, 0, 0, 0, 0, 0, 'h11111111,
                        1, 0, 'h400, 'hf, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h404, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h404, 0, 0, 0, 0, 0, 0, 0, 'h22222222,
                        1, 0, 'h404, 'hf, 0, 1, 0, 0, 'h22222222}));
    vecs.push_back(mk('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}));
    vecs.push_back(mk('{0, 0, 0, 0, 1, 0, 'h500, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 0, 0, 0, 1, 0, 'h500, 0, 0, 1, 0, 1, 0, 'h500, 'hf, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{1, 0, 0, 0, 1, 0, 'h500, 0, 0, 1, 0, 1, 0, 'h500, 'hf, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}));
    vecs.push_back(mk('{0, 0, 0, 0, 1, 1, 'h600, 'haaaa5555, 'hc, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 0, 0, 0, 1, 1, 'h600, 'haaaa5555, 'hc, 0, 0,
                        0, 1, 'h600, 'hc, 'haaaa5555, 0, 1, 0, 0}));
    vecs.push_back(mk('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}));
    vecs.push_back(mk('{0, 1, 'h480, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h480, 0, 0, 0, 0, 0, 0, 0, 'h33333333,
                        1, 0, 'h480, 'hf, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h484, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 1, 'h484, 0, 0, 0, 0, 0, 0, 0, 'h44444444,
                        1, 0, 'h484, 'hf, 0, 1, 0, 0, 'h44444444}));
    vecs.push_back(mk('{0, 0, 0, 0, 1, 0, 'h520, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}));
    vecs.push_back(mk('{0, 0, 0, 1, 1, 0, 'h520, 0, 0, 0, 'h55555555,
                        1, 0, 'h520, 'hf, 0, 0, 1, 0, 'h55555555}));
    vecs.push_back(mk('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}));
    run_vectors();

    do_reset();
    run_random(3000);
    run_starve();
`ifdef ARB_TIMEOUT_EN
    run_timeout();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
